// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: shadow destination scoreboard, RAW stalls,
// redirect flushes and memory freeze. Define FORWARDING_EN when EX/MEM/WB forwarding exists.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [1:0]  LOAD_SEL = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_ID,
  input  logic             Rs1_used,
  input  logic             Rs2_used,
  input  logic [4:0]       Rs1_addr_ID,
  input  logic [4:0]       Rs2_addr_ID,
  input  logic [4:0]       Rd_addr_ID,
  input  logic             RegWrite_ID,
  input  logic [1:0]       MemtoReg_ID,
  input  logic             redirect_EX,
  input  logic             mem_ready,
  output logic             PC_en,
  output logic             IF_ID_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_en,
  output logic             ID_EX_flush,
  output logic             EX_MEM_en,
  output logic             MEM_WB_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_dbg_o,
  output logic [19:0]      sb_dbg_o
);

  // Handshakes: valid_ID=1 means ID holds a real instruction, otherwise a bubble that never
  // hazards; mem_ready=1 means the data access completes this cycle, else the whole pipe holds.

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DSTALL = 2'd1,
    FREEZE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [4:0]       ex_rd_q, mem_rd_q, wb_rd_q;
  logic             ex_wr_q, mem_wr_q, wb_wr_q;
  logic             ex_ld_q, mem_ld_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic advance, bubble, stall_inc, flush_inc;
  logic hit_ex, hit_mem, hit_wb, stall_cond;
  logic id_wr, id_ld;

  function automatic logic src_hit(input logic wr, input logic [4:0] rd, input logic v,
                                   input logic r1u, input logic [4:0] r1,
                                   input logic r2u, input logic [4:0] r2);
    return v & wr & (rd != 5'd0) & ((r1u & (r1 == rd)) | (r2u & (r2 == rd)));
  endfunction

  always_comb begin
    hit_ex  = src_hit(ex_wr_q,  ex_rd_q,  valid_ID, Rs1_used, Rs1_addr_ID, Rs2_used, Rs2_addr_ID);
    hit_mem = src_hit(mem_wr_q, mem_rd_q, valid_ID, Rs1_used, Rs1_addr_ID, Rs2_used, Rs2_addr_ID);
    hit_wb  = src_hit(wb_wr_q,  wb_rd_q,  valid_ID, Rs1_used, Rs1_addr_ID, Rs2_used, Rs2_addr_ID);
`ifdef FORWARDING_EN
    stall_cond = hit_ex & ex_ld_q;
`else
    // No write-to-read bypass in the register file, so WB is still a hazard source.
    stall_cond = hit_ex | hit_mem | hit_wb;
`endif
  end

  always_comb begin
    state_d     = state_q;
    PC_en       = 1'b0;
    IF_ID_en    = 1'b0;
    IF_ID_flush = 1'b0;
    ID_EX_en    = 1'b0;
    ID_EX_flush = 1'b0;
    EX_MEM_en   = 1'b0;
    MEM_WB_en   = 1'b0;
    advance     = 1'b0;
    bubble      = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (!rst) begin
      state_d = RUN;
    end else if (!mem_ready) begin
      state_d = FREEZE;
    end else if (redirect_EX) begin
      PC_en       = 1'b1;
      IF_ID_en    = 1'b1;
      IF_ID_flush = 1'b1;
      ID_EX_en    = 1'b1;
      ID_EX_flush = 1'b1;
      EX_MEM_en   = 1'b1;
      MEM_WB_en   = 1'b1;
      advance     = 1'b1;
      bubble      = 1'b1;
      flush_inc   = 1'b1;
      state_d     = RUN;
    end else if (stall_cond) begin
      ID_EX_en    = 1'b1;
      ID_EX_flush = 1'b1;
      EX_MEM_en   = 1'b1;
      MEM_WB_en   = 1'b1;
      advance     = 1'b1;
      bubble      = 1'b1;
      stall_inc   = 1'b1;
      state_d     = DSTALL;
    end else begin
      PC_en     = 1'b1;
      IF_ID_en  = 1'b1;
      ID_EX_en  = 1'b1;
      EX_MEM_en = 1'b1;
      MEM_WB_en = 1'b1;
      advance   = 1'b1;
      state_d   = RUN;
    end
  end

  assign id_wr = RegWrite_ID & valid_ID & ~bubble;
  assign id_ld = (MemtoReg_ID == LOAD_SEL) & ~bubble;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      ex_rd_q     <= 5'd0;
      ex_wr_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      mem_rd_q    <= 5'd0;
      mem_wr_q    <= 1'b0;
      mem_ld_q    <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_wr_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (advance) begin
        wb_rd_q  <= mem_rd_q;
        wb_wr_q  <= mem_wr_q;
        mem_rd_q <= ex_rd_q;
        mem_wr_q <= ex_wr_q;
        mem_ld_q <= ex_ld_q;
        ex_rd_q  <= Rd_addr_ID;
        ex_wr_q  <= id_wr;
        ex_ld_q  <= id_ld;
      end
      if (stall_inc && stall_cnt_q != CNT_MAX) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (flush_inc && flush_cnt_q != CNT_MAX) flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign state_dbg_o = state_q;
  assign sb_dbg_o    = {ex_rd_q, ex_wr_q, ex_ld_q, mem_rd_q, mem_wr_q, mem_ld_q, wb_rd_q, wb_wr_q};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: per-cycle reference model feeding an expected queue,
// plus directed stall/flush/freeze/reset/saturation scenarios and a random phase.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 8;
  localparam int W     = 2 + 2 * CNT_W + 7;

  localparam logic [6:0] OUT_RUN   = 7'b1101011;
  localparam logic [6:0] OUT_STALL = 7'b0001111;
  localparam logic [6:0] OUT_REDIR = 7'b1111111;
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DSTALL = 2'd1;
  localparam logic [1:0] ST_FREEZE = 2'd2;

`ifdef FORWARDING_EN
  localparam int ADDI_STALLS = 0;
  localparam int LOAD_STALLS = 1;
`else
  localparam int ADDI_STALLS = 3;
  localparam int LOAD_STALLS = 3;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, valid_ID, Rs1_used, Rs2_used, RegWrite_ID, redirect_EX, mem_ready;
  logic [4:0] Rs1_addr_ID, Rs2_addr_ID, Rd_addr_ID;
  logic [1:0] MemtoReg_ID;
  logic PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_en;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [1:0] state_dbg_o;
  logic [19:0] sb_dbg_o;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .LOAD_SEL(2'b01)) dut (
    .clk(clk), .rst(rst), .valid_ID(valid_ID), .Rs1_used(Rs1_used), .Rs2_used(Rs2_used),
    .Rs1_addr_ID(Rs1_addr_ID), .Rs2_addr_ID(Rs2_addr_ID), .Rd_addr_ID(Rd_addr_ID),
    .RegWrite_ID(RegWrite_ID), .MemtoReg_ID(MemtoReg_ID), .redirect_EX(redirect_EX),
    .mem_ready(mem_ready), .PC_en(PC_en), .IF_ID_en(IF_ID_en), .IF_ID_flush(IF_ID_flush),
    .ID_EX_en(ID_EX_en), .ID_EX_flush(ID_EX_flush), .EX_MEM_en(EX_MEM_en),
    .MEM_WB_en(MEM_WB_en), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .state_dbg_o(state_dbg_o), .sb_dbg_o(sb_dbg_o)
  );

  int n_total = 0;
  int n_bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_obs, last_exp;

  // Reference model: index 0 = EX, 1 = MEM, 2 = WB.
  logic [4:0] m_rd[3];
  logic       m_wr[3];
  logic       m_ld[3];
  logic [1:0] m_state;
  logic [CNT_W-1:0] m_stall, m_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic m_hazard();
    logic h;
    h = 1'b0;
    if (valid_ID) begin
      for (int s = 0; s < 3; s++) begin
        if (m_wr[s] && m_rd[s] != 5'd0 &&
            ((Rs1_used && Rs1_addr_ID == m_rd[s]) || (Rs2_used && Rs2_addr_ID == m_rd[s]))) begin
`ifdef FORWARDING_EN
          if (s == 0 && m_ld[s]) h = 1'b1;
`else
          h = 1'b1;
`endif
        end
      end
    end
    return h;
  endfunction

  function automatic logic [6:0] m_outs();
    if (!rst || !mem_ready) return 7'b0;
    if (redirect_EX) return OUT_REDIR;
    if (m_hazard()) return OUT_STALL;
    return OUT_RUN;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      m_rd[s] = 5'd0;
      m_wr[s] = 1'b0;
      m_ld[s] = 1'b0;
    end
    m_state = ST_RUN;
    m_stall = '0;
    m_flush = '0;
  endtask

  task automatic model_update();
    logic haz, bub;
    if (!rst) begin
      model_reset();
    end else if (!mem_ready) begin
      m_state = ST_FREEZE;
    end else begin
      haz = m_hazard();
      bub = redirect_EX || haz;
      for (int s = 2; s > 0; s--) begin
        m_rd[s] = m_rd[s-1];
        m_wr[s] = m_wr[s-1];
        m_ld[s] = m_ld[s-1];
      end
      m_rd[0] = Rd_addr_ID;
      m_wr[0] = bub ? 1'b0 : (RegWrite_ID && valid_ID);
      m_ld[0] = bub ? 1'b0 : (MemtoReg_ID == 2'b01);
      if (redirect_EX) begin
        if (m_flush != '1) m_flush = m_flush + 1'b1;
        m_state = ST_RUN;
      end else if (haz) begin
        if (m_stall != '1) m_stall = m_stall + 1'b1;
        m_state = ST_DSTALL;
      end else begin
        m_state = ST_RUN;
      end
    end
  endtask

  // One clock: push the prediction, compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    logic [W-1:0] o;
    exp_q.push_back({m_state, m_stall, m_flush, m_outs()});
    @(negedge clk);
    o = {state_dbg_o, stall_cnt, flush_cnt, PC_en, IF_ID_en, IF_ID_flush, ID_EX_en,
         ID_EX_flush, EX_MEM_en, MEM_WB_en};
    last_obs = o;
    last_exp = exp_q.pop_front();
    chk("cycle", 32'(o), 32'(last_exp));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_id(input logic v, input logic r1u, input logic [4:0] r1, input logic r2u,
                        input logic [4:0] r2, input logic [4:0] rd, input logic rw,
                        input logic [1:0] m2r);
    valid_ID = v; Rs1_used = r1u; Rs1_addr_ID = r1; Rs2_used = r2u; Rs2_addr_ID = r2;
    Rd_addr_ID = rd; RegWrite_ID = rw; MemtoReg_ID = m2r;
  endtask

  // Presents one instruction until it leaves ID; returns the stall cycles seen on the DUT.
  task automatic issue(input logic r1u, input logic [4:0] r1, input logic r2u,
                       input logic [4:0] r2, input logic [4:0] rd, input logic rw,
                       input logic [1:0] m2r, output int stalls);
    int g;
    set_id(1'b1, r1u, r1, r2u, r2, rd, rw, m2r);
    stalls = 0;
    g = 0;
    do begin
      tick();
      if (last_obs[6:0] == OUT_STALL) stalls++;
      g++;
    end while (last_exp[6:0] == OUT_STALL && g < 8);
    set_id(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 2'b00);
  endtask

  initial begin
    int st, tot, g;
    rst = 1'b0; redirect_EX = 1'b0; mem_ready = 1'b1;
    set_id(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 2'b00);
    model_reset();

    repeat (2) tick();
    chk("reset_en", 32'(last_obs[6:0]), 32'd0);
    rst = 1'b1;
    tick();
    chk("idle_run", 32'(last_obs[6:0]), 32'(OUT_RUN));

    // addi x5 ; add x6,x5,x5
    issue(1'b1, 5'd1, 1'b0, 5'd0, 5'd5, 1'b1, 2'b00, st);
    issue(1'b1, 5'd5, 1'b1, 5'd5, 5'd6, 1'b1, 2'b00, st);
    chk("addi_raw_stalls", 32'(st), 32'(ADDI_STALLS));
    chk("addi_raw_cnt", 32'(stall_cnt), 32'(ADDI_STALLS));

    // x0 writer never hazards; unused rs2 never hazards
    issue(1'b1, 5'd2, 1'b0, 5'd0, 5'd0, 1'b1, 2'b00, st);
    issue(1'b1, 5'd0, 1'b0, 5'd0, 5'd10, 1'b1, 2'b00, st);
    chk("x0_no_stall", 32'(st), 32'd0);
    issue(1'b1, 5'd2, 1'b0, 5'd0, 5'd7, 1'b1, 2'b00, st);
    issue(1'b1, 5'd3, 1'b0, 5'd7, 5'd12, 1'b1, 2'b00, st);
    chk("rs2_unused_no_stall", 32'(st), 32'd0);

    // lw x5 ; add x6,x5,x0
    issue(1'b1, 5'd2, 1'b0, 5'd0, 5'd5, 1'b1, 2'b01, st);
    issue(1'b1, 5'd5, 1'b1, 5'd0, 5'd6, 1'b1, 2'b00, st);
    chk("load_use_stalls", 32'(st), 32'(LOAD_STALLS));
    tot = ADDI_STALLS + LOAD_STALLS;

    // redirect in the same cycle as a load-use hit
    issue(1'b1, 5'd2, 1'b0, 5'd0, 5'd8, 1'b1, 2'b01, st);
    set_id(1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 5'd13, 1'b1, 2'b00);
    redirect_EX = 1'b1;
    tick();
    chk("redir_outs", 32'(last_obs[6:0]), 32'(OUT_REDIR));
    redirect_EX = 1'b0;
    set_id(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 2'b00);
    chk("redir_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("redir_stall_held", 32'(stall_cnt), 32'(tot));
    tick();

    // freeze for 4 cycles in the middle of a data stall
    issue(1'b1, 5'd2, 1'b0, 5'd0, 5'd9, 1'b1, 2'b01, st);
    set_id(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 5'd14, 1'b1, 2'b00);
    tick();
    chk("fz_pre_stall", 32'(last_obs[6:0]), 32'(OUT_STALL));
    chk("fz_pre_state", 32'(state_dbg_o), 32'(ST_DSTALL));
    mem_ready = 1'b0;
    repeat (4) begin
      tick();
      chk("fz_all_off", 32'(last_obs[6:0]), 32'd0);
    end
    chk("fz_state", 32'(state_dbg_o), 32'(ST_FREEZE));
    chk("fz_cnt_held", 32'(stall_cnt), 32'(tot + 1));
    mem_ready = 1'b1;
    st = 1;
    g = 0;
    do begin
      tick();
      if (last_obs[6:0] == OUT_STALL) st++;
      g++;
    end while (last_exp[6:0] == OUT_STALL && g < 8);
    chk("fz_stall_total", 32'(st), 32'(LOAD_STALLS));
    set_id(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 2'b00);

    // saturate stall_cnt
    for (int i = 0; i < 300; i++) begin
      issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd11, 1'b1, 2'b01, st);
      issue(1'b1, 5'd11, 1'b0, 5'd0, 5'd15, 1'b1, 2'b00, st);
    end
    chk("sat_max", 32'(stall_cnt), 32'(8'hFF));
    issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd11, 1'b1, 2'b01, st);
    set_id(1'b1, 1'b1, 5'd11, 1'b0, 5'd0, 5'd15, 1'b1, 2'b00);
    tick();
    chk("sat_state", 32'(state_dbg_o), 32'(ST_DSTALL));
    chk("sat_hold", 32'(stall_cnt), 32'(8'hFF));

    // reset while in DSTALL with a saturated counter
    rst = 1'b0;
    tick();
    chk("rst_outs", 32'(last_obs[6:0]), 32'd0);
    rst = 1'b1;
    chk("rst_state", 32'(state_dbg_o), 32'(ST_RUN));
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    tick();
    chk("rst_no_stall", 32'(last_obs[6:0]), 32'(OUT_RUN));

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) != 0);
      if (!(m_state == ST_FREEZE)) redirect_EX = ($urandom_range(0, 9) == 0);
      mem_ready = ($urandom_range(0, 4) != 0);
      set_id(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
